// File: rtl/shift_load_reg.sv
// Command-driven 16-bit state register: clear, parallel load, N-bit serial shift
// and single-cycle invert-shift, with one-cycle done pulse and ready handshake.
module shift_load_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_INV   = 2'b11;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [CNT_W-1:0] rem_r, rem_s;
  logic [WIDTH-1:0] shift_q_s;
  logic [WIDTH-1:0] inv_shift_q_s;

  assign shift_q_s     = {q_r[WIDTH-2:0], ser_in};
  assign inv_shift_q_s = {~q_r[WIDTH-2:0], ser_in};

  // Next-state, next-q and remaining-count decode.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    rem_s   = rem_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLEAR: begin
              q_s     = '0;
              state_s = ST_DONE;
            end
            OP_LOAD: begin
              q_s     = cmd_data;
              state_s = ST_DONE;
            end
            OP_SHIFT: begin
              if (cmd_count == CNT_W'(0)) begin
                state_s = ST_DONE;
              end else begin
                // The first shift happens in the accept cycle.
                q_s   = shift_q_s;
                rem_s = cmd_count - CNT_W'(1);
                if (cmd_count == CNT_W'(1)) begin
                  state_s = ST_DONE;
                end else begin
                  state_s = ST_SHIFT;
                end
              end
            end
            OP_INV: begin
              q_s     = inv_shift_q_s;
              state_s = ST_DONE;
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        q_s = shift_q_s;
        // A zero count here is unreachable; it is folded into the final shift.
        if (rem_r <= CNT_W'(1)) begin
          rem_s   = CNT_W'(0);
          state_s = ST_DONE;
        end else begin
          rem_s   = rem_r - CNT_W'(1);
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        rem_s   = CNT_W'(0);
      end
    endcase
  end

  // State, data and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      q_r     <= '0;
      rem_r   <= CNT_W'(0);
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      rem_r   <= rem_s;
    end
  end

  assign q         = q_r;
  assign ser_out   = q_r[WIDTH-1];
  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r == ST_SHIFT);
  assign done      = (state_r == ST_DONE);

endmodule

// File: doc/shift_load_reg.md
Name: shift_load_reg

Overview:
- Registered 16-bit clear/load/shift state register.
- Consumes the next-state style controls of the combinational shift/load datapath stage and holds the state bits that stage reads back.
- Adds a command handshake, a multi-bit shift sequencer and serial in/out, so one command can run a shift of N bits.
- Sits directly downstream of the next-state logic; its q outputs feed back as that logic's current-state inputs.

Parameters:
- WIDTH, 16, register width in bits (minimum 2).
- CNT_W, 5, width of the shift-count field; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  00 CLEAR, 01 LOAD, 10 SHIFT_N, 11 INV_SHIFT.
- cmd_data  input  WIDTH  parallel load value (LOAD only).
- cmd_count  input  CNT_W  number of shifts (SHIFT_N only).
- ser_in  input  1  serial input, sampled on every shift cycle.
- ser_out  output  1  always q[WIDTH-1].
- q  output  WIDTH  current register state.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-shift):
  - q=0, state=IDLE, remaining count=0.
  - done=0, busy=0, cmd_ready=1 in the following cycle.
  - Reset overrides any command presented in the same cycle.
- FSM states: IDLE, SHIFT, DONE.
- cmd_ready=1 only in IDLE. A command is accepted when cmd_valid & cmd_ready at a clock edge. cmd_valid outside IDLE is ignored; nothing is queued.
- IDLE, command accepted:
  - CLEAR: q<=0, go to DONE.
  - LOAD: q<=cmd_data, go to DONE.
  - INV_SHIFT: q<={~q[WIDTH-2:0], ser_in}, go to DONE. This is a single cycle; only the shifted-in bit is not inverted.
  - SHIFT_N with cmd_count=0: q unchanged, go to DONE.
  - SHIFT_N with cmd_count=k>0: q<={q[WIDTH-2:0], ser_in} (first shift happens in the accept cycle), remaining<=k-1. Go to DONE if k=1, otherwise SHIFT.
- SHIFT: each cycle q<={q[WIDTH-2:0], ser_in} and remaining decrements. When a shift is taken with remaining=1, go to DONE. busy=1 throughout SHIFT.
- DONE:
  - done=1 for exactly one cycle; q holds; cmd_ready=0.
  - Next state is IDLE.
  - Command-to-done latency: 1 cycle for CLEAR/LOAD/INV_SHIFT/count 0; k cycles after accept for SHIFT_N count k.
- IDLE, no command: q holds; done=0.
- cmd_count values greater than WIDTH are legal. The shift simply runs k cycles, so the register ends up fully filled from ser_in.
- ser_out is combinational from q. Bits shifted out are not stored.
- Outputs q, busy, done and cmd_ready are registered or decoded from state only; none is combinational from inputs.
- Back-to-back commands: minimum issue interval is 2 cycles (accept, DONE, then IDLE accepts again).

Test Plan:
- Reset and load:
  - rst for 2 cycles -> q=0x0000, cmd_ready=1, done=0.
  - LOAD cmd_data=0xA5C3 -> q=0xA5C3 next cycle; done pulses the cycle after accept; cmd_ready returns to 1 one cycle later.
- Multi-shift:
  - q=0x8001, SHIFT_N k=4, ser_in=1,0,1,1 -> q=0x001B.
  - busy=1 for 3 cycles; done on the 4th cycle after accept.
  - ser_out sequence during the shift: 1,0,0,0.
- Invert shift:
  - q=0x00FF, INV_SHIFT, ser_in=0 -> q=0xFE00; done next cycle.
- Boundaries:
  - SHIFT_N k=0 -> q unchanged, done after 1 cycle, busy never set.
  - SHIFT_N k=20 with ser_in=1 -> q=0xFFFF after 20 shifts.
- Reset mid-operation:
  - SHIFT_N k=10, assert rst at shift 5 -> next cycle q=0, busy=0, no done pulse, cmd_ready=1.
- Handshake:
  - Hold cmd_valid=1 with CLEAR during SHIFT -> ignored.
  - After DONE and return to IDLE -> accepted; q=0 one cycle later.
